// File: rtl/pattern_scan_arb_pkg.sv
// Shared types and defaults for the pattern scan arbiter and its detector.
package pattern_scan_arb_pkg;

  localparam int W_DEFAULT  = 8;
  localparam int CW_DEFAULT = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } ctrl_state_t;

  typedef enum logic [1:0] {
    DET_A = 2'd0,
    DET_B = 2'd1,
    DET_C = 2'd2
  } det_state_t;

  // Round-robin grant between two requesters; last = channel served most recently.
  // A lone valid channel always wins; on a tie the channel not last served wins.
  function automatic logic [1:0] rr_grant(input logic v0, input logic v1, input logic last);
    logic [1:0] g;
    if (v0 && v1) begin
      g = last ? 2'b01 : 2'b10;
    end else begin
      g = {v1, v0};
    end
    return g;
  endfunction

endpackage

// File: rtl/seq100_det.sv
// Bit-serial detector: a 1, then a 0, then any run of 1s, then a 0 raises match
// for one cycle. The match output is registered, so it lags the bit by one cycle.
module seq100_det
  import pattern_scan_arb_pkg::*;
(
  input  logic CLK,
  input  logic RST,
  input  logic clr,
  input  logic din,
  output logic match
);

  det_state_t state_r;

  // Detector state walk with registered match; clr restarts the search.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_r <= DET_A;
      match   <= 1'b0;
    end else if (clr) begin
      state_r <= DET_A;
      match   <= 1'b0;
    end else begin
      case (state_r)
        DET_A: begin
          state_r <= din ? DET_B : DET_A;
          match   <= 1'b0;
        end
        DET_B: begin
          state_r <= din ? DET_B : DET_C;
          match   <= 1'b0;
        end
        DET_C: begin
          if (din) begin
            state_r <= DET_C;
            match   <= 1'b0;
          end else begin
            state_r <= DET_A;
            match   <= 1'b1;
          end
        end
        default: begin
          state_r <= DET_A;
          match   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/pattern_scan_arb.sv
// Two-requester front end sharing one seq100_det: grants a word round-robin,
// shifts it MSB first through the detector, counts matches and holds the result
// until the consumer takes it.
module pattern_scan_arb
  import pattern_scan_arb_pkg::*;
#(
  parameter int W  = W_DEFAULT,
  parameter int CW = CW_DEFAULT
)
(
  input  logic          CLK,
  input  logic          RST,
  input  logic          req0_valid,
  input  logic [W-1:0]  req0_data,
  output logic          req0_ready,
  input  logic          req1_valid,
  input  logic [W-1:0]  req1_data,
  output logic          req1_ready,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic          rsp_id,
  output logic [CW-1:0] rsp_count,
  output logic          busy
);

  localparam int IW = (W > 1) ? $clog2(W) : 1;

  ctrl_state_t   state_r;
  logic [W-1:0]  word_r;
  logic [IW-1:0] idx_r;
  logic [CW-1:0] count_r;
  logic          id_r;
  logic          ptr_r;

  logic [1:0]    grant_s;
  logic          in_idle_s;
  logic          accept_s;
  logic          acc_id_s;
  logic [W-1:0]  acc_data_s;
  logic          din_s;
  logic          match_s;
  logic [CW-1:0] inc_s;

  // Grant, handshake and detector feed; readies are held low while RST is asserted.
  always_comb begin
    grant_s    = rr_grant(req0_valid, req1_valid, ptr_r);
    in_idle_s  = (state_r == ST_IDLE) && !RST;
    req0_ready = in_idle_s && grant_s[0];
    req1_ready = in_idle_s && grant_s[1];
    accept_s   = (req0_valid && req0_ready) || (req1_valid && req1_ready);
    acc_id_s   = req1_valid && req1_ready;
    if (acc_id_s) begin
      acc_data_s = req1_data;
    end else begin
      acc_data_s = req0_data;
    end
    if (state_r == ST_SHIFT) begin
      din_s = word_r[idx_r];
    end else begin
      din_s = 1'b0;
    end
    inc_s = {{(CW-1){1'b0}}, match_s};
  end

  // The detector is cleared on the accept edge so a new word starts from state A.
  seq100_det u_det (
    .CLK   (CLK),
    .RST   (RST),
    .clr   (accept_s),
    .din   (din_s),
    .match (match_s)
  );

  // Controller FSM with registered response and busy outputs.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_r   <= ST_IDLE;
      word_r    <= {W{1'b0}};
      idx_r     <= IW'(W - 1);
      count_r   <= {CW{1'b0}};
      id_r      <= 1'b0;
      ptr_r     <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_id    <= 1'b0;
      rsp_count <= {CW{1'b0}};
      busy      <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            word_r  <= acc_data_s;
            id_r    <= acc_id_s;
            count_r <= {CW{1'b0}};
            idx_r   <= IW'(W - 1);
            busy    <= 1'b1;
            state_r <= ST_SHIFT;
          end else begin
            busy    <= 1'b0;
            state_r <= ST_IDLE;
          end
        end
        ST_SHIFT: begin
          // match here belongs to the previous bit; the last bit's match lands in FLUSH
          count_r <= count_r + inc_s;
          if (idx_r == {IW{1'b0}}) begin
            state_r <= ST_FLUSH;
          end else begin
            idx_r   <= idx_r - {{(IW-1){1'b0}}, 1'b1};
            state_r <= ST_SHIFT;
          end
        end
        ST_FLUSH: begin
          count_r   <= count_r + inc_s;
          rsp_count <= count_r + inc_s;
          rsp_id    <= id_r;
          rsp_valid <= 1'b1;
          state_r   <= ST_DONE;
        end
        ST_DONE: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
            ptr_r     <= id_r;
            state_r   <= ST_IDLE;
          end else begin
            state_r   <= ST_DONE;
          end
        end
        default: begin
          rsp_valid <= 1'b0;
          busy      <= 1'b0;
          state_r   <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pattern_scan_arb.sv
// Scoreboard bench for pattern_scan_arb: random and directed words from two
// requesters, expected responses from a pattern-search reference model.
module tb_pattern_scan_arb;

  localparam int W  = 8;
  localparam int CW = 4;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          req0_valid = 1'b0;
  logic [W-1:0]  req0_data = '0;
  logic          req0_ready;
  logic          req1_valid = 1'b0;
  logic [W-1:0]  req1_data = '0;
  logic          req1_ready;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic          rsp_id;
  logic [CW-1:0] rsp_count;
  logic          busy;

  pattern_scan_arb #(.W(W), .CW(CW)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .req0_valid (req0_valid),
    .req0_data  (req0_data),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_data  (req1_data),
    .req1_ready (req1_ready),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_count  (rsp_count),
    .busy       (busy)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  // model / scoreboard state
  bit           m_busy = 1'b0;
  bit           m_ptr  = 1'b1;
  int           acc_cyc = 0;
  int           sb_id[$];
  int           sb_cnt[$];
  int           id_log[$];
  logic [W-1:0] q0[$];
  logic [W-1:0] q1[$];
  bit           acc0 = 1'b0;
  bit           acc1 = 1'b0;
  int           vmode = 1;   // 1: present queued words at once, 0: random delay
  int           rmode = 0;   // 0: rsp_ready high, 1: random, 2: held low

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s @cyc %0d", name, cyc);
  endtask

  // Index of the next bit equal to v at or below position 'from', -1 if none.
  function automatic int find_bit(input logic [W-1:0] w, input int from, input logic v);
    for (int i = from; i >= 0; i--) begin
      if (w[i] == v) return i;
    end
    return -1;
  endfunction

  // Matches: a 1, later a 0, later another 0 (1s in between ignored); search restarts after each.
  function automatic int ref_count(input logic [W-1:0] w);
    int p = W - 1;
    int n = 0;
    forever begin
      p = find_bit(w, p, 1'b1);
      if (p < 0) break;
      p = find_bit(w, p - 1, 1'b0);
      if (p < 0) break;
      p = find_bit(w, p - 1, 1'b0);
      if (p < 0) break;
      n++;
      p = p - 1;
    end
    return n;
  endfunction

  // Monitor: checks handshake and response outputs against the model each falling edge.
  initial begin
    logic [1:0] er;
    forever begin
      @(negedge CLK);
      if (RST) begin
        m_busy = 1'b0;
        m_ptr  = 1'b1;
        sb_id.delete();
        sb_cnt.delete();
      end else begin
        if (m_busy) er = 2'b00;
        else if (req0_valid && req1_valid) er = m_ptr ? 2'b01 : 2'b10;
        else er = {req1_valid, req0_valid};
        chk("ready", {req1_ready, req0_ready}, er);
        chk("busy", busy, m_busy);
        chk("rsp_valid", rsp_valid, (m_busy && (cyc - acc_cyc >= W + 2)));
        if (rsp_valid) begin
          if (sb_id.size() == 0) begin
            fail_now("unexpected_rsp");
          end else begin
            chk("rsp_id", rsp_id, sb_id[0]);
            chk("rsp_count", rsp_count, sb_cnt[0]);
          end
        end
        if (rsp_valid && rsp_ready && sb_id.size() > 0) begin
          m_ptr = sb_id[0][0];
          id_log.push_back(sb_id[0]);
          void'(sb_id.pop_front());
          void'(sb_cnt.pop_front());
          m_busy = 1'b0;
        end
        if (req0_valid && req0_ready) begin
          sb_id.push_back(0);
          sb_cnt.push_back(ref_count(req0_data));
          m_busy = 1'b1;
          acc_cyc = cyc;
          acc0 = 1'b1;
        end else if (req1_valid && req1_ready) begin
          sb_id.push_back(1);
          sb_cnt.push_back(ref_count(req1_data));
          m_busy = 1'b1;
          acc_cyc = cyc;
          acc1 = 1'b1;
        end
      end
    end
  end

  // Drive inputs just after the rising edge; a presented word stays until accepted.
  task automatic tick();
    bit keep0;
    bit keep1;
    @(posedge CLK);
    #1;
    keep0 = req0_valid;
    keep1 = req1_valid;
    if (acc0) begin void'(q0.pop_front()); acc0 = 1'b0; keep0 = 1'b0; end
    if (acc1) begin void'(q1.pop_front()); acc1 = 1'b0; keep1 = 1'b0; end
    if (!keep0) req0_valid = (q0.size() > 0) && (vmode == 1 || $urandom_range(0, 2) == 0);
    if (!keep1) req1_valid = (q1.size() > 0) && (vmode == 1 || $urandom_range(0, 2) == 0);
    req0_data = (q0.size() > 0) ? q0[0] : '0;
    req1_data = (q1.size() > 0) ? q1[0] : '0;
    if (rmode == 0) rsp_ready = 1'b1;
    else if (rmode == 1) rsp_ready = ($urandom_range(0, 1) == 1);
    else rsp_ready = 1'b0;
  endtask

  task automatic wait_idle(input int lim);
    int k = 0;
    while ((q0.size() > 0 || q1.size() > 0 || m_busy || sb_id.size() > 0) && k < lim) begin
      tick();
      k++;
    end
    if (k >= lim) fail_now("drain_timeout");
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_req0_ready"}, req0_ready, 0);
    chk({tag, "_req1_ready"}, req1_ready, 0);
    chk({tag, "_rsp_valid"}, rsp_valid, 0);
    chk({tag, "_rsp_id"}, rsp_id, 0);
    chk({tag, "_rsp_count"}, rsp_count, 0);
    chk({tag, "_busy"}, busy, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout @cyc %0d", cyc);
    $fatal(1, "time limit");
  end

  initial begin
    int k;
    logic [W-1:0] w;
    // reset with both valids high: nothing may be granted
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    chk_all_zero("reset");

    // tie on the first cycle after reset: ch0, ch1, then ch0 again, then lone ch1
    @(posedge CLK);
    #1;
    q0.push_back(8'b1001_0000);
    q0.push_back(8'h00);
    q1.push_back(8'b1010_1111);
    q1.push_back(8'hFF);
    vmode = 1;
    rmode = 0;
    RST = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    req0_data = q0[0];
    req1_data = q1[0];
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    rsp_ready = 1'b1;
    wait_idle(200);
    chk("order_len", id_log.size(), 4);
    if (id_log.size() == 4) begin
      chk("order0", id_log[0], 0);
      chk("order1", id_log[1], 1);
      chk("order2", id_log[2], 0);
      chk("order3", id_log[3], 1);
    end

    // consumer stall in DONE while the other requester waits
    rmode = 2;
    q0.push_back(8'b1001_0000);
    q1.push_back(8'h5A);
    k = 0;
    while (!rsp_valid && k < 40) begin tick(); k++; end
    if (k >= 40) fail_now("stall_wait");
    repeat (5) tick();
    rmode = 0;
    wait_idle(200);

    // reset during the 4th SHIFT cycle discards the word
    q0.push_back(8'hB6);
    k = 0;
    while (!m_busy && k < 20) begin tick(); k++; end
    if (k >= 20) fail_now("abort_accept");
    k = 0;
    while (cyc != acc_cyc + 4 && k < 20) begin tick(); k++; end
    RST = 1'b1;
    tick();
    RST = 1'b0;
    @(negedge CLK);
    chk_all_zero("post_abort");
    k = id_log.size();
    q0.push_back(8'h00);
    wait_idle(200);
    chk("abort_rsp_count", id_log.size(), k + 1);

    // randomized traffic with random delays and consumer back-pressure
    vmode = 0;
    rmode = 1;
    for (int i = 0; i < 2500; i++) begin
      if (q0.size() < 2 && $urandom_range(0, 9) == 0) begin
        w = W'($urandom());
        q0.push_back(w);
      end
      if (q1.size() < 2 && $urandom_range(0, 9) == 0) begin
        case ($urandom_range(0, 5))
          0: w = 8'h00;
          1: w = 8'hFF;
          2: w = 8'hAA;
          default: w = W'($urandom());
        endcase
        q1.push_back(w);
      end
      tick();
    end
    rmode = 0;
    wait_idle(600);
    chk("final_sb_empty", sb_id.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
